// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One op in flight; operands and result are registered around the ALU.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [WIDTH-1:0]  Req0A,
    input  logic [WIDTH-1:0]  Req0B,
    input  logic [CTRL_W-1:0] Req0Ctrl,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [WIDTH-1:0]  Req1A,
    input  logic [WIDTH-1:0]  Req1B,
    input  logic [CTRL_W-1:0] Req1Ctrl,
    output logic              Rsp0Valid,
    input  logic              Rsp0Ready,
    output logic              Rsp1Valid,
    input  logic              Rsp1Ready,
    output logic [WIDTH-1:0]  RspData,
    output logic              RspZero,
    output logic [WIDTH-1:0]  AluBusA,
    output logic [WIDTH-1:0]  AluBusB,
    output logic [CTRL_W-1:0] AluCtrl,
    input  logic [WIDTH-1:0]  AluBusW,
    input  logic              AluZero
);

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;

    logic                            pri;
    logic                            gnt;
    logic [WIDTH-1:0]                op_a;
    logic [WIDTH-1:0]                op_b;
    logic [CTRL_W-1:0]               op_ctrl;
    logic [WIDTH-1:0]                rsp_data;
    logic                            rsp_zero;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              rsp_ready;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]   req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0]   req_b;
    logic [NUM_REQ-1:0][CTRL_W-1:0]  req_ctrl;

    logic                            accept;
    logic                            sel;
    logic                            rsp_fire;

    assign req_valid = {Req1Valid, Req0Valid};
    assign rsp_ready = {Rsp1Ready, Rsp0Ready};
    assign req_a     = {Req1A, Req0A};
    assign req_b     = {Req1B, Req0B};
    assign req_ctrl  = {Req1Ctrl, Req0Ctrl};

    // A lone requester always wins; on contention PRI names the winner.
    assign grant[0] = req_valid[0] & (~req_valid[1] | ~pri);
    assign grant[1] = req_valid[1] & (~req_valid[0] |  pri);
    assign sel      = grant[1];
    assign accept   = (state == IDLE) & (|grant);
    assign rsp_fire = (state == RESP) & rsp_ready[gnt];

    // Ready is masked during reset so a requester never sees a phantom accept.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign req_ready[i] = (state == IDLE) & grant[i] & ~Reset;
        assign rsp_valid[i] = (state == RESP) & (gnt == 1'(i));
    end

    assign Req0Ready = req_ready[0];
    assign Req1Ready = req_ready[1];
    assign Rsp0Valid = rsp_valid[0];
    assign Rsp1Valid = rsp_valid[1];
    assign RspData   = rsp_data;
    assign RspZero   = rsp_zero;

    // ALU inputs come straight from flops so they only move on an accept.
    assign AluBusA = op_a;
    assign AluBusB = op_b;
    assign AluCtrl = op_ctrl;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pri     <= 1'b0;
            gnt     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
        end else if (accept) begin
            pri     <= ~sel;
            gnt     <= sel;
            op_a    <= req_a[sel];
            op_b    <= req_b[sel];
            op_ctrl <= req_ctrl[sel];
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= AluBusW;
            rsp_zero <= AluZero;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: bench-side ALU model, accept-time
// scoreboard push, and an independent response monitor.
module tb_alu_share_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              Req0Valid, Req0Ready, Req1Valid, Req1Ready;
    logic [WIDTH-1:0]  Req0A, Req0B, Req1A, Req1B;
    logic [CTRL_W-1:0] Req0Ctrl, Req1Ctrl;
    logic              Rsp0Valid, Rsp0Ready, Rsp1Valid, Rsp1Ready;
    logic [WIDTH-1:0]  RspData;
    logic              RspZero;
    logic [WIDTH-1:0]  AluBusA, AluBusB, AluBusW;
    logic [CTRL_W-1:0] AluCtrl;
    logic              AluZero;

    alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .CLK(CLK), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0A(Req0A), .Req0B(Req0B), .Req0Ctrl(Req0Ctrl),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1A(Req1A), .Req1B(Req1B), .Req1Ctrl(Req1Ctrl),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready),
        .RspData(RspData), .RspZero(RspZero),
        .AluBusA(AluBusA), .AluBusB(AluBusB), .AluCtrl(AluCtrl),
        .AluBusW(AluBusW), .AluZero(AluZero)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        case (AluCtrl)
            OP_AND:  AluBusW = AluBusA & AluBusB;
            OP_OR:   AluBusW = AluBusA | AluBusB;
            OP_ADD:  AluBusW = AluBusA + AluBusB;
            OP_SUB:  AluBusW = AluBusA - AluBusB;
            default: AluBusW = '0;
        endcase
        AluZero = (AluBusW == '0);
    end

    typedef struct {
        int          port;
        logic [31:0] d;
        logic        z;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          order[$];
    logic [31:0] exp_d [2];
    logic        exp_z [2];
    int          checks = 0;
    int          errs   = 0;
    int          cyc    = 0;
    bit          in_rsp = 0;
    int          acc_p, mon_p;
    exp_t        acc_e, mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Accept side: what the DUT takes, in grant order, goes into the scoreboard.
    always @(negedge CLK) begin
        if (!Reset && (Req0Ready || Req1Ready)) begin
            if (Req0Ready && Req1Ready) chk("dual_ready", 32'd1, 32'd0);
            acc_p = Req1Ready ? 1 : 0;
            if (order.size() == 0) begin
                chk("unexpected_accept", 32'(acc_p), 32'hdead);
            end else begin
                chk("grant_order", 32'(acc_p), 32'(order.pop_front()));
            end
            acc_e.port = acc_p;
            acc_e.d    = exp_d[acc_p];
            acc_e.z    = exp_z[acc_p];
            acc_e.acc  = cyc;
            sb.push_back(acc_e);
        end
    end

    // Response side: every cycle a response is shown it must match the head entry.
    always @(negedge CLK) begin
        if (!Reset && (Rsp0Valid || Rsp1Valid)) begin
            mon_p = Rsp1Valid ? 1 : 0;
            if (Rsp0Valid && Rsp1Valid) begin
                chk("dual_rsp_valid", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(mon_p), 32'hdead);
            end else begin
                mon_e = sb[0];
                chk("rsp_port", 32'(mon_p), 32'(mon_e.port));
                chk("rsp_data", RspData, mon_e.d);
                chk("rsp_zero", 32'(RspZero), 32'(mon_e.z));
                if (!in_rsp) chk("rsp_latency", 32'(cyc - mon_e.acc), 32'd2);
                in_rsp = 1;
                if (mon_p == 1 ? Rsp1Ready : Rsp0Ready) begin
                    void'(sb.pop_front());
                    in_rsp = 0;
                end
            end
        end
    end

    // Drives one request and holds it until accepted; called at posedge+1.
    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [31:0] ed, input logic ez);
        bit got = 0;
        exp_d[p] = ed;
        exp_z[p] = ez;
        if (p == 0) begin
            Req0A = a; Req0B = b; Req0Ctrl = c; Req0Valid = 1'b1;
        end else begin
            Req1A = a; Req1B = b; Req1Ctrl = c; Req1Valid = 1'b1;
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (p == 0 ? Req0Ready : Req1Ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk($sformatf("accept_timeout_req%0d", p), 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        if (p == 0) Req0Valid = 1'b0;
        else        Req1Valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        chk("drained", 32'(sb.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errs++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        Reset = 1'b1;
        Req0Valid = 0; Req1Valid = 0;
        Req0A = '0; Req0B = '0; Req0Ctrl = '0;
        Req1A = '0; Req1B = '0; Req1Ctrl = '0;
        Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req0ready", 32'(Req0Ready), 32'd0);
        chk("rst_rsp0valid", 32'(Rsp0Valid), 32'd0);
        chk("rst_rsp1valid", 32'(Rsp1Valid), 32'd0);
        chk("rst_rspdata", RspData, 32'd0);
        chk("rst_alubusa", AluBusA, 32'd0);
        chk("rst_aluctrl", 32'(AluCtrl), 32'd0);
        Reset = 1'b0;

        // Both valid in the first cycle out of reset: req0 first, then req1.
        order.push_back(0); order.push_back(1);
        fork
            issue(0, 32'hF0, 32'h3C, OP_AND, 32'h30, 1'b0);
            issue(1, 32'hF0, 32'h0F, OP_OR,  32'hFF, 1'b0);
        join
        drain();

        order.push_back(0);
        issue(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0);
        drain();

        order.push_back(1);
        issue(1, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1);
        drain();

        // Held response: req0 waits until req1's result is taken.
        Rsp1Ready = 1'b0;
        order.push_back(1); order.push_back(0);
        issue(1, 32'd3, 32'd4, OP_ADD, 32'd7, 1'b0);
        fork
            issue(0, 32'd2, 32'd2, OP_SUB, 32'd0, 1'b1);
            begin
                repeat (5) begin
                    @(negedge CLK);
                    chk("stall_req0ready", 32'(Req0Ready), 32'd0);
                end
                @(posedge CLK);
                #1;
                Rsp1Ready = 1'b1;
            end
        join
        drain();

        // Reset during EXEC drops the op.
        order.push_back(0);
        issue(0, 32'd1, 32'd1, OP_ADD, 32'd2, 1'b0);
        Reset = 1'b1;
        #1;
        chk("midrst_rsp0valid", 32'(Rsp0Valid), 32'd0);
        chk("midrst_rspdata", RspData, 32'd0);
        chk("midrst_alubusa", AluBusA, 32'd0);
        chk("midrst_alubusb", AluBusB, 32'd0);
        chk("midrst_aluctrl", 32'(AluCtrl), 32'd0);
        sb.delete();
        in_rsp = 0;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("postrst_rsp0valid", 32'(Rsp0Valid), 32'd0);
        end
        @(posedge CLK);
        #1;

        // Continuous contention: strict alternation starting at 0 (PRI reset).
        for (int k = 0; k < 3; k++) begin
            order.push_back(0);
            order.push_back(1);
        end
        fork
            begin
                issue(0, 32'd10, 32'd3, OP_SUB, 32'd7, 1'b0);
                issue(0, 32'd6, 32'd6, OP_SUB, 32'd0, 1'b1);
                issue(0, 32'hFF, 32'h0F, OP_AND, 32'h0F, 1'b0);
            end
            begin
                issue(1, 32'd1, 32'd2, OP_ADD, 32'd3, 1'b0);
                issue(1, 32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0);
                issue(1, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0, 1'b1);
            end
        join
        drain();
        chk("order_consumed", 32'(order.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
